// File: rtl/interrupt_interface_pkg.sv
// Shared constants, FSM state type and priority helper for the interrupt interface.
package interrupt_interface_pkg;

    localparam int unsigned MIP_MSIP_BIT = 3;
    localparam int unsigned MIP_MTIP_BIT = 7;
    localparam int unsigned MIP_MEIP_BIT = 11;

    localparam logic [3:0] INT_CODE_MSI = 4'd3;
    localparam logic [3:0] INT_CODE_MTI = 4'd7;
    localparam logic [3:0] INT_CODE_MEI = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        HOLDOFF
    } intif_state_t;

    // RISC-V machine-level order: external, then software, then timer.
    function automatic logic [3:0] intif_prio(input logic [31:0] pend);
        if (pend[MIP_MEIP_BIT]) begin
            return INT_CODE_MEI;
        end else if (pend[MIP_MSIP_BIT]) begin
            return INT_CODE_MSI;
        end else if (pend[MIP_MTIP_BIT]) begin
            return INT_CODE_MTI;
        end
        return '0;
    endfunction

endpackage

// File: rtl/intif_sync.sv
// N-stage reset-to-0 flop chain for an asynchronous level; STAGES=0 is a wire.
module intif_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_chain
            logic [STAGES-1:0] sync_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d_i;
                    for (int unsigned i = 1; i < STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign q_o = sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/interrupt_interface.sv
// Captures MSIP/MTIP/MEIP into mip, masks and arbitrates them, and presents one
// held interrupt to commit with a req/ack handshake followed by a holdoff window.
module interrupt_interface
    import interrupt_interface_pkg::*;
#(
    parameter int unsigned EXT_SYNC_STAGES = 2,
    parameter int unsigned HOLDOFF_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        all_intif_int_software_req,
    input  logic        all_intif_int_timer_req,
    input  logic        all_intif_int_ext_req,
    input  logic [31:0] csr_intif_mie_data,
    input  logic        csr_intif_mstatus_mie,
    input  logic        commit_intif_ack,
    output logic [31:0] intif_csr_mip_data,
    output logic        intif_commit_has_interrupt,
    output logic [31:0] intif_commit_mcause_data
);

    logic         ext_sync;
    logic         msip_q, mtip_q, meip_q;
    logic [31:0]  mip;
    logic [31:0]  pend;
    logic         take;

    intif_state_t state_q, state_d;
    logic [3:0]   cause_q, cause_d;
    logic         cause_vld_q, cause_vld_d;
    logic [3:0]   cnt_q, cnt_d;

    intif_sync #(.STAGES(EXT_SYNC_STAGES)) u_ext_sync (
        .clk (clk),
        .rst (rst),
        .d_i (all_intif_int_ext_req),
        .q_o (ext_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_q <= 1'b0;
            mtip_q <= 1'b0;
            meip_q <= 1'b0;
        end else begin
            msip_q <= all_intif_int_software_req;
            mtip_q <= all_intif_int_timer_req;
            meip_q <= ext_sync;
        end
    end

    always_comb begin
        mip               = '0;
        mip[MIP_MSIP_BIT] = msip_q;
        mip[MIP_MTIP_BIT] = mtip_q;
        mip[MIP_MEIP_BIT] = meip_q;
    end

    assign pend = mip & csr_intif_mie_data;
    assign take = csr_intif_mstatus_mie & (|pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cause_q     <= '0;
            cause_vld_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            cause_vld_q <= cause_vld_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        cause_vld_d = cause_vld_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    cause_d     = intif_prio(pend);
                    cause_vld_d = 1'b1;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (commit_intif_ack) begin
                    cnt_d   = 4'(HOLDOFF_CYCLES);
                    state_d = HOLDOFF;
                end else if (!pend[cause_q] || !csr_intif_mstatus_mie) begin
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                // Leaving as the decremented count reaches 1 makes the IDLE
                // cycle the last quiet cycle, so the line stays low HOLDOFF_CYCLES.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd2) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign intif_csr_mip_data         = mip;
    assign intif_commit_has_interrupt = (state_q == PEND);
    assign intif_commit_mcause_data   = {cause_vld_q, 27'b0, cause_q};

endmodule
